// File: rtl/uart_baud_ctrl_if.sv
// Control and tick bundle between uart_baud_ctrl (slave) and the UART/config side (master).
interface uart_baud_ctrl_if;
  logic       baud_en;
  logic       cfg_req;
  logic [2:0] cfg_sel;
  logic       line_busy;
  logic       cfg_ack;
  logic       cfg_err;
  logic [2:0] cur_sel;
  logic       os_tick;
  logic       bit_tick;

  modport master (
    output baud_en, cfg_req, cfg_sel, line_busy,
    input  cfg_ack, cfg_err, cur_sel, os_tick, bit_tick
  );

  modport slave (
    input  baud_en, cfg_req, cfg_sel, line_busy,
    output cfg_ack, cfg_err, cur_sel, os_tick, bit_tick
  );
endinterface

// File: rtl/uart_baud_ctrl.sv
// Runtime baud-rate controller: divisor table, 16x/1x tick source and safe rate-change sequencing.
// Optional WAIT_IDLE timeout (aborts with cfg_err) is built only when UART_BAUD_TIMEOUT_EN is defined.
module uart_baud_ctrl #(
  parameter int unsigned CLK_FREQ     = 150_000_000,
  parameter int unsigned OSR          = 16,
  parameter int unsigned DIV_W        = 17,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_baud_ctrl_if.slave bus
);
  localparam int unsigned PH_W = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(OSR - 1);

  if (OSR < 4 || OSR > 16 || (OSR & (OSR - 1)) != 0 || TIMEOUT_BITS == 0) begin : g_param_check
    $error("uart_baud_ctrl: unsupported OSR or TIMEOUT_BITS");
  end

  typedef enum logic [2:0] {RUN, WAIT_IDLE, RELOAD, ACK, REL} state_t;

  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] sel);
    longint unsigned baud;
    longint unsigned den;
    case (sel)
      3'd0:    baud = 64'd1200;
      3'd1:    baud = 64'd2400;
      3'd2:    baud = 64'd4800;
      3'd3:    baud = 64'd9600;
      3'd4:    baud = 64'd14400;
      3'd5:    baud = 64'd38400;
      3'd6:    baud = 64'd57600;
      default: baud = 64'd115200;
    endcase
    den = baud * 64'(OSR);
    return DIV_W'((64'(CLK_FREQ) + den / 64'd2) / den - 64'd1);
  endfunction

  localparam logic [DIV_W-1:0] DIV_TBL [8] = '{
    div_of(3'd0), div_of(3'd1), div_of(3'd2), div_of(3'd3),
    div_of(3'd4), div_of(3'd5), div_of(3'd6), div_of(3'd7)
  };

  state_t           state_q;
  logic [2:0]       sel_pend_q;
  logic [2:0]       cur_sel_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] os_cnt_q;
  logic [PH_W-1:0]  phase_q;
  logic             cfg_ack_q;
  logic             os_tick_q;
  logic             bit_tick_q;
  logic             os_wrap_d;

  assign os_wrap_d = (os_cnt_q == div_q);

`ifdef UART_BAUD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_BITS + 1);
  logic [TO_W-1:0] tmo_q;
  logic            cfg_err_q;
  assign bus.cfg_err = cfg_err_q;
`else
  assign bus.cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sel_pend_q <= 3'd3;
      cur_sel_q  <= 3'd3;
      div_q      <= DIV_TBL[3];
      os_cnt_q   <= '0;
      phase_q    <= '0;
      cfg_ack_q  <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
`ifdef UART_BAUD_TIMEOUT_EN
      tmo_q      <= '0;
      cfg_err_q  <= 1'b0;
`endif
    end else begin
      cfg_ack_q <= 1'b0;
`ifdef UART_BAUD_TIMEOUT_EN
      cfg_err_q <= 1'b0;
`endif
      // RELOAD restarts the tick phase and swallows any tick that falls due on that edge.
      if (state_q == RELOAD) begin
        div_q      <= DIV_TBL[sel_pend_q];
        cur_sel_q  <= sel_pend_q;
        os_cnt_q   <= '0;
        phase_q    <= '0;
        os_tick_q  <= 1'b0;
        bit_tick_q <= 1'b0;
      end else if (!bus.baud_en) begin
        os_cnt_q   <= '0;
        phase_q    <= '0;
        os_tick_q  <= 1'b0;
        bit_tick_q <= 1'b0;
      end else if (os_wrap_d) begin
        os_cnt_q   <= '0;
        os_tick_q  <= 1'b1;
        phase_q    <= (phase_q == PH_MAX) ? '0 : phase_q + 1'b1;
        bit_tick_q <= (phase_q == PH_MAX);
      end else begin
        os_cnt_q   <= os_cnt_q + 1'b1;
        os_tick_q  <= 1'b0;
        bit_tick_q <= 1'b0;
      end

      case (state_q)
        RUN: if (bus.cfg_req) begin
          sel_pend_q <= bus.cfg_sel;
          state_q    <= WAIT_IDLE;
`ifdef UART_BAUD_TIMEOUT_EN
          tmo_q      <= '0;
`endif
        end
        WAIT_IDLE: begin
          if (!bus.line_busy) begin
            state_q <= RELOAD;
          end
`ifdef UART_BAUD_TIMEOUT_EN
          else if (tmo_q == TO_W'(TIMEOUT_BITS)) begin
            state_q   <= ACK;
            cfg_ack_q <= 1'b1;
            cfg_err_q <= 1'b1;
          end else if (bit_tick_q) begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        RELOAD: begin
          state_q   <= ACK;
          cfg_ack_q <= 1'b1;
        end
        ACK:     state_q <= REL;
        REL:     if (!bus.cfg_req) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.cfg_ack  = cfg_ack_q;
  assign bus.cur_sel  = cur_sel_q;
  assign bus.os_tick  = os_tick_q;
  assign bus.bit_tick = bit_tick_q;
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: a cycle-count reference model predicts every tick/ack event.
module tb_uart_baud_ctrl;
  localparam int unsigned OSR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_baud_ctrl_if bus();

  uart_baud_ctrl #(
    .CLK_FREQ(150_000_000),
    .OSR(16),
    .DIV_W(17),
    .TIMEOUT_BITS(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    longint unsigned cyc;
    bit              os;
    bit              bt;
    bit              ack;
    bit              err;
    bit [2:0]        sel;
  } ev_t;

  ev_t             exp_q[$];
  int              errors = 0;
  int              checks = 0;
  longint unsigned cyc = 0;

  // Reference state: request stage, active rate, enabled edges since the tick phase was last cleared.
  int unsigned     m_stage = 0;
  bit [2:0]        m_sel = 3'd3;
  bit [2:0]        m_pend = 3'd3;
  longint unsigned m_div = 976;
  longint unsigned m_en = 0;

  function automatic longint unsigned ref_div(input bit [2:0] s);
    int unsigned rates[8] = '{1200, 2400, 4800, 9600, 14400, 38400, 57600, 115200};
    real q;
    q = 150.0e6 / (real'(rates[s]) * real'(OSR));
    return longint'($rtoi(q + 0.5)) - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage = 0;
      m_sel   = 3'd3;
      m_div   = ref_div(3'd3);
      m_en    = 0;
      exp_q.delete();
    end else begin
      bit  clr;
      ev_t e;
      cyc = cyc + 1;
      clr = 1'b0;
      e.ack = 1'b0;
      case (m_stage)
        0: if (bus.cfg_req) begin m_pend = bus.cfg_sel; m_stage = 1; end
        1: if (!bus.line_busy) m_stage = 2;
        2: begin
          clr = 1'b1; e.ack = 1'b1;
          m_sel = m_pend; m_div = ref_div(m_pend); m_stage = 3;
        end
        3: m_stage = 4;
        default: if (!bus.cfg_req) m_stage = 0;
      endcase
      if (clr || !bus.baud_en) m_en = 0;
      else m_en = m_en + 1;
      e.cyc = cyc;
      e.err = 1'b0;
      e.sel = m_sel;
      e.os  = (m_en != 0) && (m_en % (m_div + 1) == 0);
      e.bt  = (m_en != 0) && (m_en % ((m_div + 1) * OSR) == 0);
      if (e.os || e.ack) exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      bit  have;
      have = 1'b0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        have = 1'b1;
      end else if (bus.os_tick || bus.bit_tick || bus.cfg_ack || bus.cfg_err) begin
        e = '{cyc: cyc, os: 1'b0, bt: 1'b0, ack: 1'b0, err: 1'b0, sel: m_sel};
        have = 1'b1;
      end
      if (have) begin
        checks++;
        if ({bus.os_tick, bus.bit_tick, bus.cfg_ack, bus.cfg_err, bus.cur_sel} !==
            {e.os, e.bt, e.ack, e.err, e.sel}) begin
          errors++;
          $display("FAIL tick_event cyc=%0d got os=%b bit=%b ack=%b err=%b sel=%0d want os=%b bit=%b ack=%b err=%b sel=%0d",
                   cyc, bus.os_tick, bus.bit_tick, bus.cfg_ack, bus.cfg_err, bus.cur_sel,
                   e.os, e.bt, e.ack, e.err, e.sel);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({bus.cur_sel, bus.os_tick, bus.bit_tick, bus.cfg_ack, bus.cfg_err} !== {3'd3, 4'b0000}) begin
      errors++;
      $display("FAIL %s got sel=%0d os=%b bit=%b ack=%b err=%b want sel=3 os=0 bit=0 ack=0 err=0",
               name, bus.cur_sel, bus.os_tick, bus.bit_tick, bus.cfg_ack, bus.cfg_err);
    end
  endtask

  task automatic request(input bit [2:0] sel, input bit busy, input int unsigned busy_cyc,
                         input int unsigned hold_cyc);
    bus.cfg_sel   = sel;
    bus.line_busy = busy;
    bus.cfg_req   = 1'b1;
    step(1);
    bus.cfg_sel = 3'($urandom);
    step(busy_cyc);
    bus.line_busy = 1'b0;
    step(hold_cyc);
    bus.cfg_req = 1'b0;
  endtask

  initial begin
    bus.baud_en   = 1'b1;
    bus.cfg_req   = 1'b0;
    bus.cfg_sel   = 3'd0;
    bus.line_busy = 1'b0;
    step(3);
    check_reset("reset_state");
    rst_n = 1'b1;
    step(16000);

    request(3'd7, 1'b0, 0, 3000);
    step(200);

    request(3'd0, 1'b1, 5000, 10);
    step(8000);

    request(3'd3, 1'b0, 0, 10);
    step(5000);
    bus.baud_en = 1'b0;
    step(100);
    bus.baud_en = 1'b1;
    step(16500);

    for (int i = 0; i < 8; i++) begin
      request(3'($urandom_range(3, 7)), 1'($urandom_range(0, 1)),
              $urandom_range(1, 300), $urandom_range(3, 20));
      if ($urandom_range(0, 1) == 1) begin
        bus.baud_en = 1'b0;
        step($urandom_range(1, 50));
        bus.baud_en = 1'b1;
      end
      step($urandom_range(500, 2500));
    end

    bus.cfg_sel   = 3'd7;
    bus.line_busy = 1'b1;
    bus.cfg_req   = 1'b1;
    step(50);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_wait");
    step(2);
    bus.cfg_req   = 1'b0;
    bus.line_busy = 1'b0;
    rst_n = 1'b1;
    step(2000);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
